// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled, LSB first, AXI-Stream style output with
// overrun and framing error pulses. The prescale input is latched at the start edge.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error
`endif
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                state_q, state_d;
    logic                  rxd_meta_q, rxd_sync_q, rxd_last_q;
    logic [18:0]           timer_q, timer_d;
    logic [15:0]           prescale_q, prescale_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  frame_done;

    logic [15:0]           prescale_eff;
    logic [18:0]           half_reload;
    logic [18:0]           bit_reload;
    logic                  timer_zero;
    logic                  rxd_fall;

`ifdef UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  par_err_q, par_err_d;
`endif

    // A prescale of zero behaves as one so the timer never underflows.
    assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    // Half a bit (4 ticks of 1/8 bit) from the start edge lands mid start bit.
    assign half_reload  = {1'b0, prescale_eff, 2'b00} - 19'd1;
    assign bit_reload   = {prescale_q, 3'b000} - 19'd1;
    assign timer_zero   = (timer_q == 19'd0);
    assign rxd_fall     = rxd_last_q & ~rxd_sync_q;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_last_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_last_q <= rxd_sync_q;
        end
    end

    // Frame FSM next-state: bit timing, sampling and error detection.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prescale_d  = prescale_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        frame_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Only a fresh falling edge arms; a line held low after a
                // framing error never produces one.
                if (rxd_fall) begin
                    state_d    = StStart;
                    prescale_d = prescale_eff;
                    timer_d    = half_reload;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 19'd1;
                end else if (!rxd_sync_q) begin
                    state_d = StData;
                    timer_d = bit_reload;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    shift_d = {rxd_sync_q, shift_q[DATA_WIDTH-1:1]};
                    timer_d = bit_reload;
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d = (^shift_q) ^ rxd_sync_q;
                    timer_d   = bit_reload;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 19'd1;
                end else begin
                    state_d = StIdle;
                    if (rxd_sync_q) begin
                        frame_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output word handshake; a completed frame overwrites any unread word.
    always_comb begin
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q & ~m_axis_tready;
        overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (frame_done) begin
            tdata_d   = shift_q;
            tvalid_d  = 1'b1;
            overrun_d = tvalid_q & ~m_axis_tready;
`ifdef UART_RX_PARITY_EN
            par_err_d = par_bad_q;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            prescale_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            prescale_q  <= prescale_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != StIdle);
    assign overrun_error = overrun_q;
    assign frame_error   = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at prescale=2 (16 clocks per bit).
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [15:0] prescale;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy;
    logic       overrun_error;
    logic       frame_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_hs  = 0;
    int n_ovr = 0;
    int n_fe  = 0;
    int n_pe  = 0;
    int valid_rise_cyc = 0;
    int start_cyc = 0;
    logic       tvalid_prev = 1'b0;
    logic [7:0] hs_data = 8'h00;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_axis_tvalid && !tvalid_prev) valid_rise_cyc <= cyc;
        tvalid_prev <= m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            n_hs    <= n_hs + 1;
            hs_data <= m_axis_tdata;
        end
        if (overrun_error) n_ovr <= n_ovr + 1;
        if (frame_error)   n_fe  <= n_fe + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_error)  n_pe  <= n_pe + 1;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        tick(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic use_par, input logic par_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    int hs0, ovr0, fe0, pe0;

    task automatic snap();
        hs0  = n_hs;
        ovr0 = n_ovr;
        fe0  = n_fe;
        pe0  = n_pe;
    endtask

    initial begin
        rst_n         = 1'b0;
        rxd           = 1'b1;
        prescale      = 16'd2;
        m_axis_tready = 1'b1;
        tick(3);
        check_eq("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check_eq("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ovr", {31'd0, overrun_error}, 32'd0);
        check_eq("rst_fe", {31'd0, frame_error}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Basic 0xA5 frame, latency about 152 clocks from the start edge.
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        tick(32);
        check_eq("a5_count", n_hs - hs0, 1);
        check_eq("a5_data", {24'd0, hs_data}, 32'hA5);
        check_eq("a5_latency_ok",
                 ((valid_rise_cyc - start_cyc) >= 148 && (valid_rise_cyc - start_cyc) <= 160) ? 1 : 0, 1);
        check_eq("a5_errs", (n_ovr - ovr0) + (n_fe - fe0), 0);
        check_eq("a5_tvalid_low", {31'd0, m_axis_tvalid}, 32'd0);

        // Start-bit glitch: low for 5 clocks.
        snap();
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(4);
        check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
        tick(6);
        check_eq("glitch_busy_lo", {31'd0, busy}, 32'd0);
        tick(40);
        check_eq("glitch_no_word", n_hs - hs0, 0);
        check_eq("glitch_no_err", (n_ovr - ovr0) + (n_fe - fe0), 0);

        // Overrun: consumer stalled across two frames.
        m_axis_tready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        tick(32);
        check_eq("ovr_first_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check_eq("ovr_first_data", {24'd0, m_axis_tdata}, 32'h11);
        check_eq("ovr_first_none", n_ovr - ovr0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        tick(32);
        check_eq("ovr_second_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check_eq("ovr_second_data", {24'd0, m_axis_tdata}, 32'h22);
        check_eq("ovr_pulse_count", n_ovr - ovr0, 1);
        m_axis_tready = 1'b1;
        tick(1);
        check_eq("ovr_drain", {31'd0, m_axis_tvalid}, 32'd0);
        check_eq("ovr_drain_hs", n_hs - hs0, 1);

        // Framing error: stop bit low, line held low afterwards.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(40);
        check_eq("fe_pulse_count", n_fe - fe0, 1);
        check_eq("fe_no_word", n_hs - hs0, 0);
        check_eq("fe_no_rearm", {31'd0, busy}, 32'd0);
        rxd = 1'b1;
        tick(20);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        tick(32);
        check_eq("fe_rearm_count", n_hs - hs0, 1);
        check_eq("fe_rearm_data", {24'd0, hs_data}, 32'h55);

        // Reset during data bit 3 of 0xFF, then a clean 0x5A.
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rxd = 1'b1;
        tick(8);
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(1);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        tick(200);
        check_eq("rst_mid_no_word", n_hs - hs0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        tick(32);
        check_eq("rst_mid_after_count", n_hs - hs0, 1);
        check_eq("rst_mid_after_data", {24'd0, hs_data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1.
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        tick(32);
        check_eq("par_bad_data", {24'd0, hs_data}, 32'h07);
        check_eq("par_bad_pulse", n_pe - pe0, 1);
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        tick(32);
        check_eq("par_ok_count", n_hs - hs0, 1);
        check_eq("par_ok_pulse", n_pe - pe0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port prescale  input  16  clocks per 1/8 bit (clk / (8 * baud)).
REQ-006 SHALL have port m_axis_tdata  output  DATA_WIDTH  received word.
REQ-007 SHALL have port m_axis_tvalid  output  1  word available.
REQ-008 SHALL have port m_axis_tready  input  1  consumer accepts word.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port overrun_error  output  1  one-cycle pulse, unread word overwritten.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-012 SHALL pass rxd through a 2-flop synchroniser reset to 1; all decisions use the synchronised value.
REQ-013 SHALL latch prescale at start-bit detection; a prescale of 0 SHALL be treated as 1; mid-frame prescale changes SHALL have no effect.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-015 IDLE: a 1-to-0 transition of synchronised rxd SHALL enter START with bit timer = 4*prescale - 1.
REQ-016 START: at timer 0 (mid start bit), rxd low SHALL enter DATA with timer = 8*prescale - 1; rxd high SHALL return to IDLE as a glitch, with no output and no error.
REQ-017 DATA: SHALL sample rxd each time the timer reaches 0, LSB first, reloading the timer with 8*prescale - 1; after DATA_WIDTH samples SHALL enter STOP.
REQ-018 STOP: at timer 0, rxd high SHALL complete the frame; rxd low SHALL pulse frame_error, discard the word, and wait in IDLE until rxd is high before re-arming.
REQ-019 On frame completion, m_axis_tdata SHALL update and m_axis_tvalid SHALL assert on the next clock edge, then return to IDLE.
REQ-020 m_axis_tvalid SHALL stay high and m_axis_tdata SHALL stay stable until a cycle with m_axis_tready high; it SHALL deassert on the following edge.
REQ-021 If a frame completes while m_axis_tvalid is high and m_axis_tready is low, the new word SHALL overwrite, tvalid SHALL stay high, and overrun_error SHALL pulse for one cycle.
REQ-022 A frame completing in the same cycle as a handshake SHALL not flag overrun; tvalid SHALL remain high with the new word.
REQ-023 The timer SHALL be at least 19 bits wide so that 8*65535 does not wrap.

Reset
REQ-024 On rst_n low: state=IDLE, tdata=0, tvalid=0, busy=0, overrun_error=0, frame_error=0, synchroniser=1, and the timer and bit count cleared.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no output; after release, the block SHALL re-arm only on a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: adds output parity_error (1 bit, one-cycle pulse) and a PARITY state between DATA and STOP sampling one even-parity bit.
REQ-027 With UART_RX_PARITY_EN, a parity mismatch SHALL pulse parity_error and still deliver the word; a frame error takes precedence and discards the word.
REQ-028 Macro undefined: no parity state, no parity_error port, frame = start + DATA_WIDTH + stop.

Verification
REQ-029 prescale=2, tready=1, send 0xA5 8N1 at 16 clk/bit -> tdata=0xA5 and one tvalid cycle about 152 clocks after the start edge; no errors.
REQ-030 prescale=2, rxd low for 5 clocks then high -> state returns to IDLE, no tvalid, no errors, busy low again after at most 10 clocks.
REQ-031 prescale=2, tready=0, send 0x11 then 0x22 -> tvalid held; on the second frame, tdata=0x22 and overrun_error pulses once.
REQ-032 prescale=2, send 0x3C with stop bit low -> frame_error pulses once, tvalid stays 0, no re-arm until rxd returns high.
REQ-033 Assert rst_n low during the 4th data bit of 0xFF, release, send 0x5A -> only 0x5A delivered.
REQ-034 UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> tdata=0x07 and parity_error pulses once; with parity bit 1 -> no pulse.
